// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// A one-word holding register sits in front of the shift register so the
// next frame can start the cycle after the previous stop bit ends.
module uart_tx #(
   parameter int p_CLK_DIV   = 104,
   parameter int p_WORD_LEN  = 8,
   parameter int p_PARITY    = 0,
   parameter int p_STOP_BITS = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [p_WORD_LEN-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int CNT_W = $clog2(p_CLK_DIV) + 1;
   localparam int IDX_W = $clog2(p_WORD_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(p_CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(p_CLK_DIV - 2);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(p_WORD_LEN - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(p_STOP_BITS - 1);
   localparam logic             PAR_ODD   = (p_PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [p_WORD_LEN-1:0] shift_q, shift_d, shift_nxt;
   logic [p_WORD_LEN-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ready_q, ready_d;
   logic                  load;
   logic                  cnt_last;

   // Next-state logic: holding-register accept, frame sequencing, output values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      par_d       = par_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_d        = tx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      load        = 1'b0;
      shift_nxt   = shift_q >> 1;
      cnt_last    = (cnt_q == CNT_LAST);

      // Accept only while empty; drain only while full, so they never collide.
      if (i_valid && !hold_full_q) begin
         hold_d      = i_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            cnt_d  = '0;
            idx_d  = '0;
            load   = hold_full_q;
         end
         S_START: begin
            if (cnt_last) begin
               state_d = S_DATA;
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (idx_q == DATA_LAST) begin
                  idx_d = '0;
                  if (p_PARITY != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + 1'b1;
                  shift_d = shift_nxt;
                  tx_d    = shift_nxt[0];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (cnt_last) begin
               state_d = S_STOP;
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            // Registered, so raise it one cycle early to land on the final cycle.
            done_d = (idx_q == STOP_LAST) && (cnt_q == CNT_PRE);
            if (cnt_last) begin
               cnt_d = '0;
               if (idx_q == STOP_LAST) begin
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     idx_d   = '0;
                     tx_d    = 1'b1;
                     busy_d  = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase

      // Move the held word into the shift register and start a new frame.
      if (load) begin
         state_d     = S_START;
         shift_d     = hold_q;
         par_d       = (^hold_q) ^ PAR_ODD;
         hold_full_d = 1'b0;
         cnt_d       = '0;
         idx_d       = '0;
         tx_d        = 1'b0;
         busy_d      = 1'b1;
      end

      ready_d = ~hold_full_d;
   end

   // State and registered outputs; reset aborts any frame and drops the held word.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         par_q       <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         par_q       <= par_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   assign o_tx    = tx_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_ready = ready_q;

endmodule
